// File: rtl/system_0_led_pkg.sv
// Shared constants for the system_0 LED/PWM output port: register word
// addresses and timebase widths.
package system_0_led_pkg;

    localparam int unsigned PHASE_W = 8;
    localparam int unsigned PRESC_W = 16;

    localparam int unsigned ADDR_DATA      = 0;
    localparam int unsigned ADDR_MODE      = 1;
    localparam int unsigned ADDR_PRESCALE  = 2;
    localparam int unsigned ADDR_PHASE     = 3;
    localparam int unsigned ADDR_SET       = 4;
    localparam int unsigned ADDR_CLEAR     = 5;
    localparam int unsigned ADDR_DUTY_BASE = 8;

endpackage

// File: rtl/system_0_led_timebase.sv
// Shared PWM timebase: 16-bit reloading prescaler driving an 8-bit PHASE
// counter. A load restarts the period at phase 0 without a tick.
module system_0_led_timebase
    import system_0_led_pkg::*;
#(
    parameter logic [PRESC_W-1:0] PRESCALE_RST = 16'd195
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [PRESC_W-1:0] reload,
    output logic               tick,
    output logic               wrap,
    output logic [PHASE_W-1:0] phase
);

    logic [PRESC_W-1:0] count;

    assign tick = (count == '0) && !load;
    assign wrap = tick && (phase == '1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= PRESCALE_RST;
            phase <= '0;
        end else if (load) begin
            count <= reload;
            phase <= '0;
        end else if (tick) begin
            count <= reload;
            phase <= phase + 1'b1;
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/system_0_led_pwm.sv
// Avalon-MM output port with per-bit static or PWM-dimmed outputs.
// Optional SET/CLEAR registers are enabled by defining SYSTEM_0_LED_SETCLR_EN.
module system_0_led_pwm
    import system_0_led_pkg::*;
#(
    parameter int          WIDTH        = 4,
    parameter int          ADDR_W       = 4,
    parameter logic [15:0] PRESCALE_RST = 16'd195
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic [31:0]        addr_ext;
    logic               wr;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   mode_q;
    logic [PRESC_W-1:0] prescale_q;
    logic [PHASE_W-1:0] duty_pend [WIDTH];
    logic [PHASE_W-1:0] duty_act  [WIDTH];
    logic [WIDTH-1:0]   duty_wr;
    logic               presc_load;
    logic [PRESC_W-1:0] presc_reload;
    logic               tick;
    logic               wrap;
    logic [PHASE_W-1:0] phase;
    logic               unused_bits;

    assign addr_ext   = 32'(address);
    assign wr         = chipselect && !write_n;
    assign presc_load = wr && (addr_ext == ADDR_PRESCALE);
    // A PRESCALE write restarts the count from the value being written.
    assign presc_reload = presc_load ? writedata[PRESC_W-1:0] : prescale_q;
    assign unused_bits  = ^{writedata[31:16], tick};

    always_comb begin
        duty_wr = '0;
        for (int i = 0; i < WIDTH; i++) begin
            duty_wr[i] = wr && (addr_ext == ADDR_DUTY_BASE + 32'(i));
        end
    end

    system_0_led_timebase #(
        .PRESCALE_RST(PRESCALE_RST)
    ) u_timebase (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (presc_load),
        .reload (presc_reload),
        .tick   (tick),
        .wrap   (wrap),
        .phase  (phase)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q     <= '0;
            mode_q     <= '0;
            prescale_q <= PRESCALE_RST;
        end else begin
            if (wr && (addr_ext == ADDR_DATA)) begin
                data_q <= writedata[WIDTH-1:0];
`ifdef SYSTEM_0_LED_SETCLR_EN
            end else if (wr && (addr_ext == ADDR_SET)) begin
                data_q <= data_q | writedata[WIDTH-1:0];
            end else if (wr && (addr_ext == ADDR_CLEAR)) begin
                data_q <= data_q & ~writedata[WIDTH-1:0];
`endif
            end
            if (wr && (addr_ext == ADDR_MODE)) begin
                mode_q <= writedata[WIDTH-1:0];
            end
            if (presc_load) begin
                prescale_q <= writedata[PRESC_W-1:0];
            end
        end
    end

    // Active duties only change on a period wrap; a write landing on the
    // wrap edge bypasses the pending register so it is not lost for a period.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                duty_pend[i] <= '0;
                duty_act[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (duty_wr[i]) begin
                    duty_pend[i] <= writedata[PHASE_W-1:0];
                end
                if (wrap) begin
                    duty_act[i] <= duty_wr[i] ? writedata[PHASE_W-1:0] : duty_pend[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                out_port[i] <= mode_q[i] ? (data_q[i] && (phase < duty_act[i])) : data_q[i];
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (addr_ext == ADDR_DATA) begin
            readdata = 32'(data_q);
        end else if (addr_ext == ADDR_MODE) begin
            readdata = 32'(mode_q);
        end else if (addr_ext == ADDR_PRESCALE) begin
            readdata = 32'(prescale_q);
        end else if (addr_ext == ADDR_PHASE) begin
            readdata = 32'(phase);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (addr_ext == ADDR_DUTY_BASE + 32'(i)) begin
                readdata = 32'(duty_pend[i]);
            end
        end
    end

endmodule

// File: tb/tb_system_0_led_pwm.sv
// Scoreboard bench for system_0_led_pwm: a cycle-level reference model derives
// phase arithmetically from the cycles elapsed since the last prescaler load.
module tb_system_0_led_pwm;

    localparam int W = 4;

    logic        clk;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] out_port;

    system_0_led_pwm #(
        .WIDTH(W),
        .ADDR_W(4),
        .PRESCALE_RST(16'd195)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        logic         rd;
        logic [3:0]   a;
        logic [31:0]  rdv;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int           m_data, m_mode, m_presc, m_k;
    int           m_pend[W];
    int           m_act[W];
    logic [W-1:0] m_out;

    function automatic int m_phase();
        return (m_k / (m_presc + 1)) % 256;
    endfunction

    function automatic bit m_next_wrap();
        return ((m_k + 1) % (256 * (m_presc + 1))) == 0;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'(m_data);
        if (a == 1) return 32'(m_mode);
        if (a == 2) return 32'(m_presc);
        if (a == 3) return 32'(m_phase());
        if (a >= 8 && a < 8 + W) return 32'(m_pend[a-8]);
        return 32'd0;
    endfunction

    task automatic model_edge(input logic rn, input logic we, input int a, input logic [31:0] wd);
        logic [W-1:0] nout;
        bit ld, wrp;
        if (!rn) begin
            m_data = 0; m_mode = 0; m_presc = 195; m_k = 0; m_out = '0;
            for (int i = 0; i < W; i++) begin m_pend[i] = 0; m_act[i] = 0; end
            return;
        end
        for (int i = 0; i < W; i++)
            nout[i] = m_mode[i] ? (m_data[i] && (m_phase() < m_act[i])) : m_data[i];
        ld  = we && (a == 2);
        wrp = !ld && m_next_wrap();
        if (we) begin
            if (a == 0) m_data = int'(wd[W-1:0]);
            if (a == 1) m_mode = int'(wd[W-1:0]);
            if (a == 2) m_presc = int'(wd[15:0]);
`ifdef SYSTEM_0_LED_SETCLR_EN
            if (a == 4) m_data = m_data | int'(wd[W-1:0]);
            if (a == 5) m_data = m_data & ~int'(wd[W-1:0]) & ((1 << W) - 1);
`endif
            if (a >= 8 && a < 8 + W) m_pend[a-8] = int'(wd[7:0]);
        end
        if (wrp)
            for (int i = 0; i < W; i++) m_act[i] = m_pend[i];
        m_k   = ld ? 0 : m_k + 1;
        m_out = nout;
    endtask

    // Drive one cycle: push the expected view for this cycle, then advance the model at the edge.
    task automatic step(input logic rn, input logic cs, input logic wn, input logic [3:0] a,
                        input logic [31:0] wd, input logic chk_rd);
        exp_t e;
        reset_n = rn; chipselect = cs; write_n = wn; address = a; writedata = wd;
        e.out = m_out;
        e.rd  = chk_rd && rn;
        e.a   = a;
        e.rdv = m_read(int'(a));
        sbq.push_back(e);
        @(posedge clk);
        model_edge(rn, cs && !wn, int'(a), wd);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b1, 1'b1, a, 32'd0, 1'b1);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)), 32'($urandom), 1'b1);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            if (out_port !== mon_e.out) begin
                errors++;
                $display("FAIL out_port actual=%b required=%b t=%0t", out_port, mon_e.out, $time);
            end
            if (mon_e.rd) begin
                checks++;
                if (readdata !== mon_e.rdv) begin
                    errors++;
                    $display("FAIL readdata[addr %0d] actual=%h required=%h t=%0t",
                             mon_e.a, readdata, mon_e.rdv, $time);
                end
            end
        end
    end

    int hc[W];
    int exp_hc[W];

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 0, 32'd0);
        #1;
        repeat (2) step(1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 1'b0);
        rd(4'd2);
        rd(4'd3);

        // Static mode
        wr(4'd1, 32'h0);
        wr(4'd0, 32'hA);
        idle();
        rd(4'd0);
        repeat (4) idle();

        // Reset mid-activity
        wr(4'd2, 32'd0); wr(4'd1, 32'h5); wr(4'd8, 32'd100); wr(4'd0, 32'hF);
        repeat (50) idle();
        repeat (3) step(1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 1'b0);
        rd(4'd2); rd(4'd3); rd(4'd0); rd(4'd8);
        repeat (3) idle();

        // PWM duty high counts
        wr(4'd2, 32'd0); wr(4'd1, 32'hF); wr(4'd0, 32'hF);
        wr(4'd8, 32'd0); wr(4'd9, 32'd64); wr(4'd10, 32'd128); wr(4'd11, 32'd255);
        repeat (300) idle();
        for (int i = 0; i < W; i++) hc[i] = 0;
        exp_hc = '{0, 64, 128, 255};
        repeat (256) begin
            idle();
            for (int i = 0; i < W; i++) hc[i] += int'(out_port[i]);
        end
        for (int i = 0; i < W; i++) begin
            checks++;
            if (hc[i] != exp_hc[i]) begin
                errors++;
                $display("FAIL high_count[%0d] actual=%0d required=%0d", i, hc[i], exp_hc[i]);
            end
        end

        // Duty buffering: mid-period write, then write coincident with wrap
        repeat (100) idle();
        wr(4'd9, 32'd20);
        rd(4'd9);
        for (int n = 0; n < 600 && !m_next_wrap(); n++) idle();
        wr(4'd9, 32'd77);
        rd(4'd9);
        repeat (300) idle();

        // Prescaler restart and full phase cycle
        wr(4'd2, 32'd3);
        repeat (1030) rd(4'd3);
        rd(4'd2);

        // SET / CLEAR
        wr(4'd1, 32'h0);
        wr(4'd0, 32'h3);
        wr(4'd4, 32'h4);
        rd(4'd0);
        wr(4'd5, 32'h1);
        rd(4'd0);
        rd(4'd4); rd(4'd5);

        // Randomized traffic with occasional resets
        repeat (3000) begin
            int r;
            logic [3:0] a;
            logic [31:0] d;
            r = int'($urandom_range(0, 99));
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            if (a == 4'd2) d = 32'($urandom_range(0, 3));
            if (r < 1) step(1'b0, 1'b0, 1'b1, a, d, 1'b0);
            else if (r < 25) wr(a, d);
            else idle();
        end

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/system_0_led_pwm.md
Name: system_0_led_pwm

Overview:
- Parametrised Avalon-MM slave output port that drives WIDTH LED or general outputs.
- Each bit is either static (driven directly from the DATA register) or PWM-dimmed with its own 8-bit duty cycle.
- All channels share one prescaled timebase.
- Sits on the system interconnect as a drop-in successor to the plain 4-bit output port.

Parameters:
- WIDTH, 4, number of output bits/channels (1..8).
- ADDR_W, 4, Avalon word-address width; 2**ADDR_W >= 8+WIDTH.
- PRESCALE_RST, 16'd195, prescaler reload value after reset. Tick period is PRESCALE+1 clk cycles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low, sampled on posedge clk.
- address  in  ADDR_W  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe. Write occurs when chipselect && !write_n.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address, zero wait states, unused bits 0.
- out_port  out  WIDTH  registered outputs.

Behaviour:
- Register map (word addresses):
  - 0 DATA rw [WIDTH-1:0]
  - 1 MODE rw [WIDTH-1:0], 1=PWM
  - 2 PRESCALE rw [15:0]
  - 3 PHASE ro [7:0]
  - 4 SET wo (optional)
  - 5 CLEAR wo (optional)
  - 6..7 reserved
  - 8+i DUTY[i] rw [7:0]
  - Reserved, unimplemented and write-only addresses read 0 and ignore writes.
- Reset (reset_n=0 at posedge):
  - DATA, MODE, PHASE, all DUTY and active duties = 0.
  - PRESCALE = PRESCALE_RST; prescaler counter = PRESCALE_RST.
  - out_port = 0.
  - Reset applies mid-PWM-period with no residue.
- Timebase:
  - 16-bit down-counter; when 0 it asserts tick for one cycle and reloads PRESCALE, otherwise decrements.
  - On tick PHASE increments, 255 wraps to 0; wrap = tick && PHASE==255.
  - PRESCALE=0 gives a tick every cycle.
- PRESCALE write: the counter loads the new value and PHASE clears to 0 on the same edge; no tick that cycle.
- DUTY double-buffered:
  - A write updates pending DUTY[i], which is readable immediately.
  - The active duty takes the pending value on the next wrap edge, so there are no partial periods.
  - If the write coincides with a wrap, the written value becomes active on that same edge.
- Output per bit i, registered, 1-cycle latency from register/phase change:
  - MODE[i]=0: out_port[i] <= DATA[i].
  - MODE[i]=1: out_port[i] <= DATA[i] && (PHASE < active_duty[i]).
  - Duty 0 = always off; duty 255 = on 255 of 256 phases. DATA[i] gates the PWM channel.
- DATA/MODE writes are visible on out_port one cycle after the write edge. Read-after-write returns the new value in the next cycle.

Optional Feature:
- Macro: SYSTEM_0_LED_SETCLR_EN.
- Defined:
  - Write to SET: DATA <= DATA | writedata[WIDTH-1:0].
  - Write to CLEAR: DATA <= DATA & ~writedata[WIDTH-1:0].
  - Both read 0.
- Undefined: addresses 4 and 5 are reserved, and writes to them have no effect.

Decomposition:
- Package system_0_led_pkg holds:
  - address constants ADDR_DATA, ADDR_MODE, ADDR_PRESCALE, ADDR_PHASE, ADDR_SET, ADDR_CLEAR, ADDR_DUTY_BASE;
  - PHASE_W=8, PRESC_W=16.
- One sub-module, system_0_led_timebase: prescaler + PHASE counter. Inputs: load and reload value. Outputs: tick, wrap, phase.
- Register file, duty buffers and output compare stay in the top.

Test Plan:
- Reset check: hold reset_n=0 for 3 cycles mid-activity -> out_port=0, readdata at address 2 = 195, and PHASE=0 after release.
- Static mode: write DATA=4'b1010 with MODE=0 -> out_port=4'b1010 exactly one cycle after the write edge. Read address 0 returns 32'h0000000A.
- PWM duty: PRESCALE=0, MODE=4'hF, DATA=4'hF, DUTY = 0, 64, 128, 255, then wait for a wrap. Over 256 cycles the per-bit high counts are 0, 64, 128, 255.
- Duty buffering: a DUTY[1] write mid-period does not change the out_port[1] pattern until after the wrap edge, and the read returns the new value immediately. A write coincident with the wrap applies on that edge.
- Prescaler: write PRESCALE=3 -> PHASE=0, then increments every 4 cycles, and 255 wraps to 0 after 1024 cycles.
- SETCLR (macro defined): DATA=4'b0011, write SET=4'b0100 -> 4'b0111, write CLEAR=4'b0001 -> 4'b0110. With the macro undefined, the same writes leave DATA at 4'b0011.
